// File: rtl/riscv_pkg.sv
// Shared types and encodings for the memory responder.
//   MEM_ctrl        : processor request control word {proc_req, we}
//   REQUEST/READ/WRITE : encodings of the control fields
//   mem_resp_state  : responder FSM state
//   is_misaligned() : true when a byte offset is not word-aligned
package riscv_pkg;

    localparam logic REQUEST    = 1'b1;
    localparam logic NO_REQUEST = 1'b0;
    localparam logic READ       = 1'b0;
    localparam logic WRITE      = 1'b1;

    typedef struct packed {
        logic proc_req;
        logic we;
    } MEM_ctrl;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_resp_state;

    function automatic logic is_misaligned(input logic [1:0] byte_offset);
        return byte_offset != 2'b00;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the memory responder: DEPTH x 32 bits, organised as four
// independent byte lanes so each lane maps onto its own block RAM with a
// plain write enable. Write and read are synchronous; read data is registered.
// Contents are never cleared.
// Ports:
//   clk   : clock
//   en    : access strobe (read always, write when we=1)
//   we    : write enable
//   be    : byte enables, bit i gates wdata[8i+7:8i]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
module mem_resp_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
                lane_rd_reg <= lane_mem[addr];
            end
        end

        assign rdata[8*gi +: 8] = lane_rd_reg;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts a processor load/store, inserts LATENCY wait
// states (BUSY_out high), then reports completion with a one-cycle VALID_out
// pulse carrying load data. A new request may be accepted in the completion
// cycle, giving back-to-back operation.
// Optional feature: define MEM_RESP_MISALIGN_ERR_EN to flag accesses whose
// ADDR_in[1:0] is non-zero; such accesses keep normal timing, do not store,
// return zero data and pulse ERR_out alongside VALID_out. Without the macro
// the low address bits are ignored and ERR_out stays 0.
// Ports:
//   CLK        : clock
//   RSTn       : synchronous active-low reset
//   MEMctrl_in : request control {proc_req, we}
//   ADDR_in    : byte address
//   WDATA_in   : store data
//   BE_in      : store byte enables
//   BUSY_out   : access in progress (registered)
//   VALID_out  : one-cycle completion pulse
//   RDATA_out  : load data while VALID_out=1, otherwise 0
//   ERR_out    : misalignment flag, pulses with VALID_out
module mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  MEM_ctrl     MEMctrl_in,
    input  logic [31:0] ADDR_in,
    input  logic [31:0] WDATA_in,
    input  logic [3:0]  BE_in,
    output logic        BUSY_out,
    output logic        VALID_out,
    output logic [31:0] RDATA_out,
    output logic        ERR_out
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    mem_resp_state state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;

    // Request captured at acceptance, used when the access fires from WAIT.
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          we_reg;
    logic          mis_reg;

    logic          busy_reg, valid_reg, err_reg, load_reg;

    logic          accept, fire, from_regs, mis_in;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_we, acc_mis;
    logic          arr_en, arr_we;
    logic [31:0]   arr_rdata;

`ifdef MEM_RESP_MISALIGN_ERR_EN
    assign mis_in = is_misaligned(ADDR_in[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    // Requests arriving while waiting are ignored; the requester holds them.
    assign accept = RSTn && (state_reg != WAIT) && (MEMctrl_in.proc_req == REQUEST);

    // With zero latency the access fires on the accepting edge straight from
    // the inputs; otherwise it fires from WAIT using the captured request.
    assign from_regs = (state_reg == WAIT);
    assign acc_addr  = from_regs ? addr_reg  : ADDR_in[AW+1:2];
    assign acc_wdata = from_regs ? wdata_reg : WDATA_in;
    assign acc_be    = from_regs ? be_reg    : BE_in;
    assign acc_we    = from_regs ? we_reg    : MEMctrl_in.we;
    assign acc_mis   = from_regs ? mis_reg   : mis_in;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fire       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_next = DONE;
                        fire       = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset at the firing edge must abort the access, so the array is gated too.
    assign arr_en = fire && RSTn;
    assign arr_we = (acc_we == WRITE) && !acc_mis;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            load_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next == WAIT);
            valid_reg <= fire;
            err_reg   <= fire && acc_mis;
            load_reg  <= fire && (acc_we == READ) && !acc_mis;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_reg  <= ADDR_in[AW+1:2];
            wdata_reg <= WDATA_in;
            be_reg    <= BE_in;
            we_reg    <= MEMctrl_in.we;
            mis_reg   <= mis_in;
        end
    end

    mem_resp_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (CLK),
        .en    (arr_en),
        .we    (arr_we),
        .be    (acc_be),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign BUSY_out  = busy_reg;
    assign VALID_out = valid_reg;
    assign ERR_out   = err_reg;
    assign RDATA_out = load_reg ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with LATENCY=2 and one
// with LATENCY=0 (both DEPTH=16). Stimulus pushes the hand-computed response
// of each request into a per-instance queue; a monitor per instance pops and
// compares whenever VALID_out is seen, including the number of BUSY_out
// cycles that preceded it. Define MEM_RESP_MISALIGN_ERR_EN to build the
// misalignment variant.
module tb_mem_responder;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          busy;
        bit          b2b;
        string       name;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RSTn;
    MEM_ctrl     ctrl2, ctrl0;
    logic [31:0] addr2, wdata2, addr0, wdata0;
    logic [3:0]  be2, be0;
    logic        busy2, valid2, err2, busy0, valid0, err0;
    logic [31:0] rd2, rd0;

    int n_vec = 0;
    int n_err = 0;
    exp_t q2[$];
    exp_t q0[$];

    mem_responder #(.DEPTH(16), .LATENCY(2)) dut2 (
        .CLK(CLK), .RSTn(RSTn), .MEMctrl_in(ctrl2), .ADDR_in(addr2),
        .WDATA_in(wdata2), .BE_in(be2), .BUSY_out(busy2), .VALID_out(valid2),
        .RDATA_out(rd2), .ERR_out(err2)
    );

    mem_responder #(.DEPTH(16), .LATENCY(0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .MEMctrl_in(ctrl0), .ADDR_in(addr0),
        .WDATA_in(wdata0), .BE_in(be0), .BUSY_out(busy0), .VALID_out(valid0),
        .RDATA_out(rd0), .ERR_out(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int bc2 = 0;
    bit pv2 = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RSTn) begin
            bc2 = 0;
            pv2 = 1'b0;
        end else begin
            if (valid2) begin
                check("dut2_busy_with_valid", 32'(busy2), 32'd0);
                if (q2.size() == 0) begin
                    check("dut2_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    check({e.name, "_rdata"}, rd2, e.rdata);
                    check({e.name, "_err"}, 32'(err2), 32'(e.err));
                    check({e.name, "_busy_cycles"}, 32'(bc2), 32'(e.busy));
                    if (e.b2b) check({e.name, "_b2b"}, 32'(pv2), 32'd1);
                    $display("txn dut2 %s: rdata=%h err=%0b busy_cycles=%0d", e.name, rd2, err2, bc2);
                end
                bc2 = 0;
            end else begin
                if (busy2) bc2++;
                check("dut2_idle_rdata", rd2, 32'd0);
                check("dut2_idle_err", 32'(err2), 32'd0);
            end
            pv2 = valid2;
        end
    end

    int bc0 = 0;
    bit pv0 = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RSTn) begin
            bc0 = 0;
            pv0 = 1'b0;
        end else begin
            if (valid0) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check({e.name, "_rdata"}, rd0, e.rdata);
                    check({e.name, "_err"}, 32'(err0), 32'(e.err));
                    check({e.name, "_busy_cycles"}, 32'(bc0), 32'(e.busy));
                    if (e.b2b) check({e.name, "_b2b"}, 32'(pv0), 32'd1);
                    $display("txn dut0 %s: rdata=%h err=%0b busy_cycles=%0d", e.name, rd0, err0, bc0);
                end
                bc0 = 0;
            end else begin
                check("dut0_idle_rdata", rd0, 32'd0);
            end
            if (busy0) bc0++;
            pv0 = valid0;
        end
    end

    // ---------------- stimulus helpers ----------------
    // LATENCY=2 request: held through WAIT, dropped in the completion cycle.
    task automatic txn2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input string name);
        exp_t e;
        int   n;
        e.rdata = exp_rd; e.err = exp_err; e.busy = 2; e.b2b = 1'b0; e.name = name;
        q2.push_back(e);
        ctrl2.proc_req = REQUEST; ctrl2.we = we;
        addr2 = addr; wdata2 = wdata; be2 = be;
        @(posedge CLK); #1;
        n = 0;
        while (busy2 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        ctrl2.proc_req = NO_REQUEST;
        @(posedge CLK); #1;
    endtask

    // LATENCY=0 request: accepted at the next edge, request left asserted so
    // a following call forms a back-to-back pair.
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input bit b2b,
                        input string name);
        exp_t e;
        e.rdata = exp_rd; e.err = 1'b0; e.busy = 0; e.b2b = b2b; e.name = name;
        q0.push_back(e);
        ctrl0.proc_req = REQUEST; ctrl0.we = we;
        addr0 = addr; wdata0 = wdata; be0 = be;
        @(posedge CLK); #1;
    endtask

    task automatic idle0();
        ctrl0.proc_req = NO_REQUEST;
        @(posedge CLK); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RSTn = 1'b0;
        ctrl2 = '0; addr2 = '0; wdata2 = '0; be2 = '0;
        ctrl0 = '0; addr0 = '0; wdata0 = '0; be0 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy2",  32'(busy2),  32'd0);
        check("rst_valid2", 32'(valid2), 32'd0);
        check("rst_rdata2", rd2,         32'd0);
        check("rst_err2",   32'(err2),   32'd0);
        check("rst_busy0",  32'(busy0),  32'd0);
        check("rst_valid0", 32'(valid0), 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // LATENCY=0: stores, then back-to-back loads, then store->load pair
        txn0(WRITE, 32'h0, 32'h0101_0101, 4'hF, 32'h0, 1'b0, "l0_st_0");
        idle0();
        txn0(WRITE, 32'h4, 32'h0202_0202, 4'hF, 32'h0, 1'b0, "l0_st_4");
        idle0();
        txn0(READ,  32'h0, 32'h0, 4'h0, 32'h0101_0101, 1'b0, "l0_ld_0");
        txn0(READ,  32'h4, 32'h0, 4'h0, 32'h0202_0202, 1'b1, "l0_ld_4_b2b");
        idle0();
        txn0(WRITE, 32'h8, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, "l0_st_8");
        txn0(READ,  32'h8, 32'h0, 4'h0, 32'hAABB_CCDD, 1'b1, "l0_ld_8_b2b");
        idle0();

        // LATENCY=2
        txn2(WRITE, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "st_10_full");
        txn2(READ,  32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_10_a");
        txn2(WRITE, 32'h10, 32'h1122_3344, 4'h3, 32'h0, 1'b0, "st_10_be3");
        txn2(READ,  32'h10, 32'h0, 4'h0, 32'hDEAD_3344, 1'b0, "ld_10_b");
        txn2(WRITE, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "st_10_be0");
        txn2(READ,  32'h10, 32'h0, 4'h0, 32'hDEAD_3344, 1'b0, "ld_10_c");
        txn2(WRITE, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "st_20");
        txn2(READ,  32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "ld_20_a");

        // Store aborted by reset in the second wait cycle
        ctrl2.proc_req = REQUEST; ctrl2.we = WRITE;
        addr2 = 32'h20; wdata2 = 32'h1234_5678; be2 = 4'hF;
        @(posedge CLK); #1;
        check("abort_wait1_busy", 32'(busy2), 32'd1);
        @(posedge CLK); #1;
        check("abort_wait2_busy", 32'(busy2), 32'd1);
        RSTn = 1'b0;
        ctrl2.proc_req = NO_REQUEST;
        @(posedge CLK); #1;
        check("abort_busy",  32'(busy2),  32'd0);
        check("abort_valid", 32'(valid2), 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;
        txn2(READ,  32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "ld_20_after_abort");

        // Address wrap modulo DEPTH words and partial byte lanes
        txn2(WRITE, 32'h1004, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, "st_1004_wrap");
        txn2(READ,  32'h4, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, "ld_4_a");
        txn2(WRITE, 32'h44, 32'h9988_7766, 4'hC, 32'h0, 1'b0, "st_44_beC");
        txn2(READ,  32'h4, 32'h0, 4'h0, 32'h9988_A5A5, 1'b0, "ld_4_b");
        txn2(READ,  32'h50, 32'h0, 4'h0, 32'hDEAD_3344, 1'b0, "ld_50_wrap");

`ifdef MEM_RESP_MISALIGN_ERR_EN
        txn2(WRITE, 32'h12, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "st_12_misaligned");
        txn2(READ,  32'h10, 32'h0, 4'h0, 32'hDEAD_3344, 1'b0, "ld_10_after_mis");
        txn2(READ,  32'h11, 32'h0, 4'h0, 32'h0, 1'b1, "ld_11_misaligned");
`else
        txn2(WRITE, 32'h13, 32'h0000_000D, 4'h1, 32'h0, 1'b0, "st_13_offset_ignored");
        txn2(READ,  32'h10, 32'h0, 4'h0, 32'hDEAD_330D, 1'b0, "ld_10_d");
`endif

        repeat (3) @(posedge CLK);
        #1;
        check("dut2_pending_responses", 32'(q2.size()), 32'd0);
        check("dut0_pending_responses", 32'(q0.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
